// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 Set-2 bytes into {ext, brk, code} key events
// and queues them in a first-word-fall-through FIFO. BAT (AA) and ACK (FA)
// responses are reported as sticky flags.
// Optional build macro: PS2_REPEAT_FILTER_EN drops typematic auto-repeat makes.
module ps2_key_decoder #(
  parameter int ADDR_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       rd_en,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       bat_ok,
  output logic       ack_seen
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t state_q, state_d;

  // byte classification
  logic is_e0, is_f0, is_abort, is_idle_drop;
  assign is_e0        = (rx_data == 8'hE0);
  assign is_f0        = (rx_data == 8'hF0);
  assign is_abort     = (rx_data == 8'hAA) || (rx_data == 8'hFA) ||
                        (rx_data == 8'hEE) || (rx_data == 8'hFE) ||
                        (rx_data == 8'h00) || (rx_data == 8'hFF);
  // E1 only matters as a leading byte; inside a prefix it is treated as a code
  assign is_idle_drop = is_abort || (rx_data == 8'hE1);

  // decoder state register; reset drops any partial prefix
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // prefix sequencing: E0/F0 accumulate, anything else ends the sequence
  always_comb begin
    state_d = state_q;
    if (rx_done_tick) begin
      case (state_q)
        IDLE:    state_d = is_e0 ? EXT : (is_f0 ? BRK : IDLE);
        EXT:     state_d = is_f0 ? EXT_BRK : (is_e0 ? EXT : IDLE);
        BRK:     state_d = is_e0 ? EXT_BRK : (is_f0 ? BRK : IDLE);
        EXT_BRK: state_d = (is_e0 || is_f0) ? EXT_BRK : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // event/status outputs of the decoder for the current byte
  logic ev_vld, ev_ext, ev_brk, set_bat, set_ack;
  always_comb begin
    ev_vld  = 1'b0;
    ev_ext  = (state_q == EXT) || (state_q == EXT_BRK);
    ev_brk  = (state_q == BRK) || (state_q == EXT_BRK);
    set_bat = rx_done_tick && (rx_data == 8'hAA);
    set_ack = rx_done_tick && (rx_data == 8'hFA);
    if (rx_done_tick && !is_e0 && !is_f0)
      ev_vld = (state_q == IDLE) ? !is_idle_drop : !is_abort;
  end

  logic enq;

`ifdef PS2_REPEAT_FILTER_EN
  logic [8:0] held_q, held_d;
  logic       held_vld_q, held_vld_d;
  logic       held_match;

  assign held_match = held_vld_q && (held_q == {ev_ext, rx_data});
  // a make of the key already held down is an auto-repeat
  assign enq        = ev_vld && !(!ev_brk && held_match);

  // track the last make; its matching break releases it
  always_comb begin
    held_d     = held_q;
    held_vld_d = held_vld_q;
    if (enq) begin
      if (!ev_brk) begin
        held_d     = {ev_ext, rx_data};
        held_vld_d = 1'b1;
      end else if (held_match) begin
        held_vld_d = 1'b0;
      end
    end
  end

  // held-key register
  always_ff @(posedge clk) begin
    if (reset) begin
      held_q     <= '0;
      held_vld_q <= 1'b0;
    end else begin
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
    end
  end
`else
  assign enq = ev_vld;
`endif

  // FIFO control: a full FIFO still accepts a write when the head pops
  logic              push_ok, pop_ok, drop;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              empty_q, full_q, ovf_q, bat_q, ack_q;
  logic [9:0]        mem_q [2**ADDR_W];

  assign pop_ok  = rd_en && !empty_q;
  assign push_ok = enq && (!full_q || rd_en);
  assign drop    = enq && full_q && !rd_en;

  // next pointers and occupancy
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO bookkeeping and sticky status
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      bat_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= (cnt_d == '0);
      full_q   <= (cnt_d == DEPTH);
      ovf_q    <= ovf_q | drop;
      bat_q    <= bat_q | set_bat;
      ack_q    <= ack_q | set_ack;
    end
  end

  // entry storage; contents are masked by empty, so no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {ev_ext, ev_brk, rx_data};
  end

  logic [9:0] head;
  assign head      = empty_q ? 10'd0 : mem_q[rd_ptr_q];
  assign key_ext   = head[9];
  assign key_break = head[8];
  assign key_code  = head[7:0];
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = ovf_q;
  assign bat_ok    = bat_q;
  assign ack_seen  = ack_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: stimulus pushes expected key events,
// a monitor pops and compares each entry the FIFO hands out on rd_en.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       reset, rx_done_tick, rd_en;
  logic [7:0] rx_data;
  logic [7:0] key_code;
  logic       key_break, key_ext, empty, full, overflow, bat_ok, ack_seen;

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_key_decoder #(.ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .rd_en(rd_en), .key_code(key_code), .key_break(key_break), .key_ext(key_ext),
    .empty(empty), .full(full), .overflow(overflow), .bat_ok(bat_ok),
    .ack_seen(ack_seen)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every accepted pop must match the oldest expected event
  always @(negedge clk) begin
    if (!reset && rd_en && !empty) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got {%0b,%0b,0x%02h} expected none",
                 key_ext, key_break, key_code);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({key_ext, key_break, key_code} !== e) begin
          fails++;
          $display("FAIL pop_entry: got {%0b,%0b,0x%02h} expected {%0b,%0b,0x%02h}",
                   key_ext, key_break, key_code, e[9], e[8], e[7:0]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_done_tick = 1'b1;
    rx_data      = b;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic expect_ev(input logic ext, input logic brk, input logic [7:0] c);
    exp_q.push_back({ext, brk, c});
  endtask

  // pop everything out, bounded, then confirm scoreboard and FIFO agree
  task automatic drain(input string name);
    for (int i = 0; i < 40 && !empty; i++) pop();
    check({name, "_sb_left"}, exp_q.size(), 0);
    check({name, "_empty"}, empty, 1'b1);
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00; rd_en = 1'b0;
    do_reset();

    // reset state
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_bat", bat_ok, 1'b0);
    check("rst_ack", ack_seen, 1'b0);
    check("rst_head", {key_ext, key_break, key_code}, 10'h000);

    // pop while empty has no effect
    pop();
    check("pop_empty_empty", empty, 1'b1);

    // single make, one-cycle latency to empty=0
    expect_ev(0, 0, 8'h1C);
    send(8'h1C);
    check("make_lat_empty", empty, 1'b0);
    check("make_head", {key_ext, key_break, key_code}, {2'b00, 8'h1C});
    pop();
    check("make_popped_empty", empty, 1'b1);
    check("make_popped_head", key_code, 8'h00);

    // extended break: no entry until the final byte
    send(8'hE0);
    check("e0_no_entry", empty, 1'b1);
    send(8'hF0);
    check("e0f0_no_entry", empty, 1'b1);
    expect_ev(1, 1, 8'h75);
    send(8'h75);
    check("extbrk_head", {key_ext, key_break, key_code}, {2'b11, 8'h75});
    drain("extbrk");

    // plain break and idle discards
    expect_ev(0, 1, 8'h29);
    send(8'hF0); send(8'h29);
    drain("brk");
    send(8'hEE); send(8'hE1); send(8'hFF);
    check("idle_discard", empty, 1'b1);

    // controller responses, abort inside a prefix
    send(8'hAA);
    send(8'hFA);
    check("bat_set", bat_ok, 1'b1);
    check("ack_set", ack_seen, 1'b1);
    check("resp_no_entry", empty, 1'b1);
    send(8'hF0); send(8'hAA);
    check("abort_no_entry", empty, 1'b1);
    check("abort_bat", bat_ok, 1'b1);
    expect_ev(0, 0, 8'h1C);
    send(8'h1C);
    check("after_abort_head", {key_ext, key_break, key_code}, {2'b00, 8'h1C});
    drain("abort");

    // fill to full, ninth event overflows
    for (int i = 0; i < 8; i++) begin
      expect_ev(0, 0, 8'h15 + 8'(i));
      send(8'h15 + 8'(i));
    end
    check("fill_full", full, 1'b1);
    check("fill_no_ovf", overflow, 1'b0);
    send(8'h1D);
    check("ovf_set", overflow, 1'b1);
    check("ovf_full", full, 1'b1);
    // enqueue with simultaneous pop while full: both happen
    expect_ev(0, 0, 8'h1E);
    rd_en = 1'b1; rx_done_tick = 1'b1; rx_data = 8'h1E;
    @(posedge clk); #1;
    rd_en = 1'b0; rx_done_tick = 1'b0; rx_data = 8'h00;
    check("simul_full", full, 1'b1);
    check("simul_ovf", overflow, 1'b1);
    drain("fill");

    // enqueue with rd_en while empty: enqueue only
    expect_ev(0, 0, 8'h33);
    rd_en = 1'b1; rx_done_tick = 1'b1; rx_data = 8'h33;
    @(posedge clk); #1;
    rd_en = 1'b0; rx_done_tick = 1'b0; rx_data = 8'h00;
    check("simul_empty_head", key_code, 8'h33);
    drain("simul_empty");

    // reset mid-prefix discards the prefix and sticky flags
    send(8'hE0);
    do_reset();
    check("rst2_ovf", overflow, 1'b0);
    check("rst2_bat", bat_ok, 1'b0);
    check("rst2_ack", ack_seen, 1'b0);
    expect_ev(0, 0, 8'h74);
    send(8'h74);
    check("rst2_head", {key_ext, key_break, key_code}, {2'b00, 8'h74});
    drain("rst2");

    // typematic repeat sequence
    expect_ev(0, 0, 8'h1C);
`ifndef PS2_REPEAT_FILTER_EN
    expect_ev(0, 0, 8'h1C);
    expect_ev(0, 0, 8'h1C);
`endif
    expect_ev(0, 1, 8'h1C);
    expect_ev(0, 0, 8'h1C);
`ifndef PS2_REPEAT_FILTER_EN
    expect_ev(0, 0, 8'h1C);
`endif
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C);
    send(8'h1C); send(8'h1C);
`ifdef PS2_REPEAT_FILTER_EN
    // the last make above is a repeat of a re-pressed key
`endif
    drain("repeat");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sits directly downstream of the PS/2 byte receiver.
- Consumes its byte strobe (rx_done_tick) and 8-bit data byte, and interprets Set-2 prefix bytes (E0 extended, F0 break).
- Queues complete key events {extended, break, code} in a small first-word-fall-through FIFO for the application (display/control logic), which pops them with a read strobe.
- Also reports the receiver's controller-response bytes (BAT, ACK) as sticky status.

Parameters:
- ADDR_W, 3, FIFO address width; depth = 2**ADDR_W entries (8 default); legal range 1..5.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- rx_done_tick  in  1  one-cycle strobe: new byte valid on rx_data
- rx_data  in  8  byte from the PS/2 receiver
- rd_en  in  1  pop head entry (ignored when empty=1)
- key_code  out  8  head entry scan code (valid when empty=0)
- key_break  out  1  head entry is a release (F0 seen)
- key_ext  out  1  head entry is extended (E0 seen)
- empty  out  1  FIFO holds no entries
- full  out  1  FIFO holds 2**ADDR_W entries
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- bat_ok  out  1  sticky: 0xAA received
- ack_seen  out  1  sticky: 0xFA received

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE; FIFO pointers and count = 0.
  - empty=1, full=0, overflow=0, bat_ok=0, ack_seen=0.
  - key_code=0x00, key_break=0, key_ext=0 (outputs read 0 whenever empty=1).
  - Reset asserted mid-sequence discards any partial prefix.
- Bytes are processed only on cycles with rx_done_tick=1; rx_data is ignored otherwise.
- Decoder FSM, 4 states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
  - IDLE: E0 -> EXT; F0 -> BRK.
  - IDLE: AA -> set bat_ok, stay IDLE. FA -> set ack_seen, stay IDLE. EE, FE, 00, FF, E1 -> discarded, stay IDLE.
  - IDLE: any other byte -> enqueue {ext=0, brk=0, code}, stay IDLE.
  - EXT: F0 -> EXT_BRK. E0 -> stay EXT. Any other byte -> enqueue {1, 0, code}, -> IDLE.
  - BRK: F0 -> stay BRK. E0 -> EXT_BRK. Other -> enqueue {0, 1, code}, -> IDLE.
  - EXT_BRK: E0 or F0 -> stay. Other -> enqueue {1, 1, code}, -> IDLE.
  - In EXT/BRK/EXT_BRK, bytes AA/FA/EE/FE/00/FF abort the sequence -> IDLE; the sticky flags are still set for AA/FA.
- Enqueue: the entry is written on the same clk edge as the final byte's rx_done_tick. empty deasserts and head outputs are valid the following cycle, i.e. 1 cycle from rx_done_tick to empty=0.
- FIFO, first-word-fall-through: key_code, key_break and key_ext are driven from the head entry.
  - rd_en=1 with empty=0 advances the head at the clock edge.
  - rd_en with empty=1: no effect.
- Full: an enqueue with full=1 and rd_en=0 is dropped; overflow is set and held until reset.
- Simultaneous enqueue and pop:
  - When full: both occur, count unchanged, no overflow.
  - When empty: only the enqueue occurs (rd_en ignored).
- Pointers are ADDR_W bits and wrap modulo 2**ADDR_W; the count is ADDR_W+1 bits.
- full and empty are registered, consistent with the count after each edge.

Optional Feature:
- Macro: PS2_REPEAT_FILTER_EN
- Defined:
  - Typematic suppression. A register holds {ext, code} of the last enqueued make plus a held_valid flag.
  - A make equal to the held key while held_valid=1 is discarded; it is not enqueued and never counts toward overflow.
  - A different make is enqueued and replaces the held key.
  - A break matching the held key is enqueued and clears held_valid.
  - Reset clears held_valid.
- Undefined: every make is enqueued, including auto-repeats. No held-key registers exist.

Test Plan:
- Byte 1C -> after 1 cycle empty=0, key_code=0x1C, key_break=0, key_ext=0; pulse rd_en -> empty=1.
- Bytes E0,F0,75 -> one entry {ext=1, brk=1, 0x75}; FSM returns to IDLE; no entries after E0 or F0 alone.
- Bytes AA then FA -> bat_ok=1, ack_seen=1, empty stays 1. Then F0,AA -> aborts, bat_ok still 1, no entry; next byte 1C -> {0, 0, 0x1C}.
- ADDR_W=3: 9 makes 15..1D with rd_en=0 -> full=1 after 8, overflow=1, popping yields 15..1C in order; then make 1E with simultaneous rd_en while full -> count stays 8, overflow unchanged.
- Reset asserted after E0 mid-sequence, then byte 74 -> entry {0, 0, 0x74}, all sticky flags 0.
- With PS2_REPEAT_FILTER_EN: 1C,1C,1C,F0,1C,1C -> entries {0,0,1C}, {0,1,1C}, {0,0,1C}. Without the macro -> five entries in order.
